// File: rtl/vector_dot_product_sequencer.sv
// Time-multiplexed M31 dot product: one multiplier and one adder walk VECTOR_SIZE element pairs.
// Optional feature macro: DOT_SEQ_LEN_CFG_EN (adds cfg_len, a per-job length).
module vector_dot_product_sequencer #(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16,
    parameter int ADDR_WIDTH  = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_valid,
    output logic                  start_ready,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [WORD_WIDTH-1:0] rd_data1,
    input  logic [WORD_WIDTH-1:0] rd_data2,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ready
`ifdef DOT_SEQ_LEN_CFG_EN
    ,
    input  logic [ADDR_WIDTH:0]   cfg_len
`endif
);
    localparam int W  = WORD_WIDTH;
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [W-1:0]  P      = '1;
    localparam logic [LW-1:0] VS_LEN = LW'(VECTOR_SIZE);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN1, DRAIN2, DONE} state_t;

    state_t          state, nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [LW-1:0]   len_q, len_eff;
    logic [W-1:0]    p_reg, acc;
    logic [1:0]      vld_pipe;
    logic            accept, last;

    // Mersenne reduction: 2^W == 1 mod p, so the high half folds onto the low half.
    function automatic logic [W-1:0] m31_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0]   x, y;
        logic [2*W-1:0] prod;
        logic [W:0]     f1, f2;
        x    = (a == P) ? '0 : a;
        y    = (b == P) ? '0 : b;
        prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        f1   = {1'b0, prod[2*W-1:W]} + {1'b0, prod[W-1:0]};
        f2   = {{W{1'b0}}, f1[W]} + {1'b0, f1[W-1:0]};
        return (f2 == {1'b0, P}) ? '0 : f2[W-1:0];
    endfunction

    function automatic logic [W-1:0] m31_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

`ifdef DOT_SEQ_LEN_CFG_EN
    assign len_eff = (cfg_len > VS_LEN) ? VS_LEN : cfg_len;
`else
    assign len_eff = VS_LEN;
`endif

    assign accept  = (state == IDLE) && start_valid;
    assign last    = ({1'b0, cnt} == (len_q - 1'b1));
    assign rd_addr = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt          = state;
        start_ready  = 1'b0;
        rd_en        = 1'b0;
        result_valid = 1'b0;
        result       = '0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) nxt = (len_eff == '0) ? DRAIN1 : ISSUE;
            end
            ISSUE: begin
                rd_en = 1'b1;
                if (last) nxt = DRAIN1;
            end
            DRAIN1: nxt = DRAIN2;
            DRAIN2: nxt = DONE;
            DONE: begin
                result_valid = 1'b1;
                result       = acc;
                if (result_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // vld_pipe[0]: buffer data present this cycle; vld_pipe[1]: p_reg holds a product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            len_q    <= '0;
            p_reg    <= '0;
            acc      <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], rd_en};
            if (vld_pipe[0]) p_reg <= m31_mul(rd_data1, rd_data2);
            if (vld_pipe[1]) acc   <= m31_add(acc, p_reg);
            if (accept) begin
                cnt   <= '0;
                acc   <= '0;
                len_q <= len_eff;
            end else if (rd_en && !last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
